// File: rtl/frame_stream_generator.sv
// ---------------------------------------------------------------------------
// frame_stream_generator
//
// Purpose:
//   Transmit side of the sync-framed pixel stream. Reads a stored frame
//   row-major from an external synchronous-read RAM and replays it with
//   programmable line blanking (h_sync low between rows) and frame blanking
//   (v_sync high before/after the pixels, v_sync low between frames in
//   continuous mode).
//
// Ports:
//   i_clk          clock
//   i_rst          synchronous active-high reset
//   i_start        start one frame (sampled only while idle)
//   i_continuous   1 = restart automatically after P_V_GAP low cycles
//   o_rd_en        RAM read enable (high exactly while a line is being read)
//   o_rd_addr      RAM read address, row*P_IMAGE_WIDTH + col
//   i_rd_data      RAM read data, valid one cycle after o_rd_en
//   o_v_sync       frame-active level
//   o_h_sync       line-active / pixel-valid level
//   o_image_data   pixel, forced to 0 while o_h_sync is low
//   o_busy         controller is not idle
//   o_frame_done   one-cycle pulse on the first v_sync-low cycle after a frame
// ---------------------------------------------------------------------------
module frame_stream_generator #(
  parameter int P_IMAGE_WIDTH  = 256,
  parameter int P_IMAGE_HEIGHT = 256,
  parameter int P_PIXEL_WIDTH  = 8,
  parameter int P_ADDR_WIDTH   = 16,
  parameter int P_H_BLANK      = 16,
  parameter int P_V_PRE        = 4,
  parameter int P_V_POST       = 4,
  parameter int P_V_GAP        = 64
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_start,
  input  logic                     i_continuous,
  output logic                     o_rd_en,
  output logic [P_ADDR_WIDTH-1:0]  o_rd_addr,
  input  logic [P_PIXEL_WIDTH-1:0] i_rd_data,
  output logic                     o_v_sync,
  output logic                     o_h_sync,
  output logic [P_PIXEL_WIDTH-1:0] o_image_data,
  output logic                     o_busy,
  output logic                     o_frame_done
);

  localparam int COL_W = $clog2(P_IMAGE_WIDTH);
  localparam int ROW_W = $clog2(P_IMAGE_HEIGHT);

  // One shared timer covers every blanking state, so it is sized for the
  // longest of them.
  localparam int MAX_PRE_POST = (P_V_PRE > P_V_POST) ? P_V_PRE : P_V_POST;
  localparam int MAX_BLANK    = (P_H_BLANK > P_V_GAP) ? P_H_BLANK : P_V_GAP;
  localparam int TIMER_MAX    = (MAX_PRE_POST > MAX_BLANK) ? MAX_PRE_POST : MAX_BLANK;
  localparam int TIMER_W      = $clog2(TIMER_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_V_PRE,
    S_LINE,
    S_H_BLANK,
    S_V_POST,
    S_V_GAP
  } state_t;

  state_t                   state;
  state_t                   state_next;
  logic [TIMER_W-1:0]       timer;
  logic [COL_W-1:0]         col;
  logic [ROW_W-1:0]         row;
  logic [P_ADDR_WIDTH-1:0]  addr;
  logic                     timer_last;
  logic                     col_last;
  logic                     row_last;
  logic                     v_level;
  logic                     h_level;
  logic [1:0]               v_pipe;
  logic [1:0]               h_pipe;
  logic [P_PIXEL_WIDTH-1:0] data_q;
  logic                     done_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic plus the unregistered v/h levels that feed the
  // two-stage alignment pipeline.
  always_comb begin
    state_next = state;
    timer_last = 1'b0;
    col_last   = (col == COL_W'(P_IMAGE_WIDTH - 1));
    row_last   = (row == ROW_W'(P_IMAGE_HEIGHT - 1));
    v_level    = 1'b0;
    h_level    = 1'b0;
    case (state)
      S_IDLE: begin
        if (i_start) state_next = S_V_PRE;
      end
      S_V_PRE: begin
        v_level    = 1'b1;
        timer_last = (timer == TIMER_W'(P_V_PRE - 1));
        if (timer_last) state_next = S_LINE;
      end
      S_LINE: begin
        v_level = 1'b1;
        h_level = 1'b1;
        if (col_last) state_next = row_last ? S_V_POST : S_H_BLANK;
      end
      S_H_BLANK: begin
        v_level    = 1'b1;
        timer_last = (timer == TIMER_W'(P_H_BLANK - 1));
        if (timer_last) state_next = S_LINE;
      end
      S_V_POST: begin
        v_level    = 1'b1;
        timer_last = (timer == TIMER_W'(P_V_POST - 1));
        if (timer_last) state_next = i_continuous ? S_V_GAP : S_IDLE;
      end
      S_V_GAP: begin
        timer_last = (timer == TIMER_W'(P_V_GAP - 1));
        if (timer_last) state_next = S_V_PRE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Position counters. The timer restarts whenever a timed state ends, and
  // the address is held (not incremented) on the very last pixel so it can
  // never wrap within a frame; it is cleared outside the line/blank region
  // so every frame starts reading from address 0.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      timer <= '0;
      col   <= '0;
      row   <= '0;
      addr  <= '0;
    end else begin
      if (state == S_IDLE || state == S_LINE || timer_last) begin
        timer <= '0;
      end else begin
        timer <= timer + TIMER_W'(1);
      end

      if (state == S_LINE && !col_last) begin
        col <= col + COL_W'(1);
      end else begin
        col <= '0;
      end

      if (state == S_LINE && col_last) begin
        row <= row_last ? '0 : row + ROW_W'(1);
      end else if (state != S_LINE && state != S_H_BLANK) begin
        row <= '0;
      end

      if (state == S_LINE) begin
        if (!(col_last && row_last)) addr <= addr + P_ADDR_WIDTH'(1);
      end else if (state != S_H_BLANK) begin
        addr <= '0;
      end
    end
  end

  // Two register stages on the sync levels line them up with the pixel,
  // which arrives one cycle after the read and is registered once more.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      v_pipe <= '0;
      h_pipe <= '0;
      data_q <= '0;
      done_q <= 1'b0;
    end else begin
      v_pipe <= {v_pipe[0], v_level};
      h_pipe <= {h_pipe[0], h_level};
      data_q <= h_pipe[0] ? i_rd_data : '0;
      done_q <= v_pipe[1] & ~v_pipe[0];
    end
  end

  assign o_rd_en      = (state == S_LINE);
  assign o_rd_addr    = addr;
  assign o_v_sync     = v_pipe[1];
  assign o_h_sync     = h_pipe[1];
  assign o_image_data = data_q;
  assign o_busy       = (state != S_IDLE);
  assign o_frame_done = done_q;

endmodule

// File: tb/tb_frame_stream_generator.sv
// ---------------------------------------------------------------------------
// tb_frame_stream_generator
//
// Purpose:
//   Self-checking bench for frame_stream_generator on a small frame
//   (4x3 pixels, short blanking). The stimulus side fills a RAM model with
//   random pixels and queues the expected frames/pixels; a monitor samples
//   the DUT on the falling edge and pops the queues as the stream appears.
// ---------------------------------------------------------------------------
module tb_frame_stream_generator;

  localparam int W     = 4;
  localparam int H     = 3;
  localparam int PW    = 8;
  localparam int AW    = 4;
  localparam int HB    = 2;
  localparam int VPRE  = 1;
  localparam int VPOST = 1;
  localparam int VGAP  = 3;

  typedef struct {
    int vlen;
    int gap;
  } frame_t;

  logic          clk;
  logic          rst;
  logic          start;
  logic          continuous;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [PW-1:0] rd_data;
  logic          v_sync;
  logic          h_sync;
  logic [PW-1:0] image_data;
  logic          busy;
  logic          frame_done;

  logic [PW-1:0] ram [0:(1<<AW)-1];

  frame_t        exp_frames [$];
  logic [PW-1:0] exp_pix [$];

  int checks;
  int errors;
  int done_cnt;
  int lines;

  frame_stream_generator #(
    .P_IMAGE_WIDTH (W),
    .P_IMAGE_HEIGHT(H),
    .P_PIXEL_WIDTH (PW),
    .P_ADDR_WIDTH  (AW),
    .P_H_BLANK     (HB),
    .P_V_PRE       (VPRE),
    .P_V_POST      (VPOST),
    .P_V_GAP       (VGAP)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start),
    .i_continuous(continuous),
    .o_rd_en     (rd_en),
    .o_rd_addr   (rd_addr),
    .i_rd_data   (rd_data),
    .o_v_sync    (v_sync),
    .o_h_sync    (h_sync),
    .o_image_data(image_data),
    .o_busy      (busy),
    .o_frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read RAM model
  always @(posedge clk) begin
    if (rd_en) rd_data <= ram[rd_addr];
  end

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // Reference model: a frame is W*H pixels in address order, framed by the
  // pre/post periods and H-1 line gaps.
  task automatic push_frame(input int gap);
    frame_t f;
    f.vlen = VPRE + W * H + (H - 1) * HB + VPOST;
    f.gap  = gap;
    exp_frames.push_back(f);
    for (int i = 0; i < W * H; i++) exp_pix.push_back(ram[i]);
  endtask

  // Fills the RAM, queues n frames, pulses start and checks start latency.
  task automatic apply_stimulus(input logic cont, input int n);
    repeat ($urandom_range(1, 5)) @(posedge clk);
    for (int i = 0; i < (1 << AW); i++) ram[i] = PW'($urandom);
    for (int f = 0; f < n; f++) push_frame(f == 0 ? -1 : VGAP);
    #1;
    continuous = cont;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_output("busy_after_start", busy, 1);
    check_output("v_sync_cycle_k", v_sync, 0);
    @(posedge clk); #1;
    check_output("v_sync_cycle_k1", v_sync, 0);
    @(posedge clk); #1;
    check_output("v_sync_cycle_k2", v_sync, 1);
    check_output("h_sync_cycle_k2", h_sync, 0);
    repeat (VPRE) @(posedge clk);
    #1;
    check_output("h_sync_first_pixel", h_sync, 1);
  endtask

  task automatic wait_done(input int target, input int budget);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    check_output("frame_done_timeout", (done_cnt >= target) ? 1 : 0, 1);
  endtask

  task automatic wait_line(input int done_target, input int line, input int budget);
    int n = 0;
    #1;
    while (!(h_sync && lines == line && done_cnt == done_target) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check_output("wait_line_timeout", (n < budget) ? 1 : 0, 1);
  endtask

  task automatic end_checks();
    repeat (VGAP + 8) @(posedge clk);
    #1;
    check_output("busy_idle", busy, 0);
    check_output("pixels_left", exp_pix.size(), 0);
    check_output("frames_left", exp_frames.size(), 0);
  endtask

  task automatic run_continuous(input int n);
    int base = done_cnt;
    apply_stimulus(1'b1, n);
    wait_line(base + n - 1, 2, 60 * n);
    continuous = 1'b0;
    wait_done(base + n, 100 * n);
    end_checks();
  endtask

  // Monitor: compares every falling-edge sample against the queued model.
  int     prev_v, prev_h, v_run, v_low_run, h_run, h_low;
  logic   cur_valid;
  frame_t cur;

  always @(negedge clk) begin
    if (rst) begin
      prev_v = 0; prev_h = 0; v_run = 0; v_low_run = 0;
      h_run = 0; h_low = 0; lines = 0; cur_valid = 1'b0;
    end else begin
      if (h_sync) begin
        if (exp_pix.size() == 0) begin
          check_output("unexpected_pixel", 1, 0);
        end else begin
          check_output("pixel", image_data, exp_pix.pop_front());
        end
      end else begin
        check_output("data_zero_when_idle", image_data, 0);
      end
      if (rd_en) check_output("rd_addr_range", (rd_addr < W * H) ? 1 : 0, 1);

      if (v_sync && prev_v == 0) begin
        if (exp_frames.size() == 0) begin
          check_output("unexpected_frame", 1, 0);
          cur_valid = 1'b0;
        end else begin
          cur = exp_frames.pop_front();
          cur_valid = 1'b1;
          if (cur.gap >= 0) check_output("v_gap_len", v_low_run, cur.gap);
        end
        v_run = 0;
        lines = 0;
      end
      if (!v_sync && prev_v == 1) begin
        check_output("frame_done_on_fall", frame_done, 1);
        if (cur_valid) check_output("v_high_len", v_run, cur.vlen);
        check_output("lines_per_frame", lines, H);
        cur_valid = 1'b0;
        v_low_run = 0;
      end else if (frame_done) begin
        check_output("unexpected_frame_done", 1, 0);
      end
      if (frame_done) done_cnt++;
      if (v_sync) v_run++; else v_low_run++;

      if (h_sync && prev_h == 0) begin
        if (lines > 0) check_output("h_blank_len", h_low, HB);
        lines++;
        h_run = 0;
      end
      if (!h_sync && prev_h == 1) begin
        check_output("h_line_len", h_run, W);
        h_low = 0;
      end
      if (h_sync) h_run++; else h_low++;

      prev_v = v_sync;
      prev_h = h_sync;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int base;
    checks = 0; errors = 0; done_cnt = 0; lines = 0;
    rst = 1'b1; start = 1'b0; continuous = 1'b0;
    for (int i = 0; i < (1 << AW); i++) ram[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_v_sync", v_sync, 0);
    check_output("reset_h_sync", h_sync, 0);
    check_output("reset_busy", busy, 0);
    check_output("reset_rd_en", rd_en, 0);
    check_output("reset_rd_addr", rd_addr, 0);
    check_output("reset_frame_done", frame_done, 0);
    rst = 1'b0;

    $display("[TB] single frame");
    apply_stimulus(1'b0, 1);
    wait_done(1, 100);
    end_checks();

    $display("[TB] continuous two frames");
    run_continuous(2);

    $display("[TB] start pulses while busy");
    base = done_cnt;
    apply_stimulus(1'b0, 1);
    for (int p = 0; p < 3; p++) begin
      repeat ($urandom_range(1, 2)) @(posedge clk);
      #1;
      if (busy) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    wait_done(base + 1, 100);
    end_checks();

    $display("[TB] reset mid-frame");
    base = done_cnt;
    apply_stimulus(1'b0, 1);
    wait_line(base, 3, 100);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_output("midreset_v_sync", v_sync, 0);
    check_output("midreset_h_sync", h_sync, 0);
    check_output("midreset_data", image_data, 0);
    check_output("midreset_busy", busy, 0);
    check_output("midreset_rd_en", rd_en, 0);
    check_output("midreset_rd_addr", rd_addr, 0);
    check_output("midreset_frame_done", frame_done, 0);
    exp_pix.delete();
    exp_frames.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    check_output("no_done_after_reset", done_cnt, base);
    apply_stimulus(1'b0, 1);
    wait_done(base + 1, 100);
    end_checks();

    $display("[TB] random continuous runs");
    for (int r = 0; r < 3; r++) run_continuous($urandom_range(1, 3));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
